// File: rtl/systolic_ws_array.sv
// Weight-stationary ROWS x COLS systolic array with integrated input skew, output deskew
// and a weight-load sequencer. Define SYSTOLIC_WS_SAT_EN to saturate outputs instead of wrapping.
module systolic_ws_array #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DW   = 16,
    parameter int AW   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    input  logic [$clog2(COLS+1)-1:0] cfg_cols,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [COLS*DW-1:0]        w_data,
    input  logic                      w_last,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [ROWS*DW-1:0]        a_data,
    input  logic                      a_last,
    output logic                      o_valid,
    output logic [COLS*AW-1:0]        o_data,
    output logic                      o_last,
    output logic [2:0]                state
);
    localparam int SW  = 2*DW + $clog2(ROWS);
    localparam int PW  = 2*DW;
    localparam int L   = ROWS + COLS;
    localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CCW = $clog2(COLS+1);
    localparam logic [CCW-1:0] COLS_C = CCW'(COLS);

    typedef enum logic [2:0] {
        S_EMPTY  = 3'd0,
        S_LOAD   = 3'd1,
        S_LOADED = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CW-1:0]        r_wcnt, w_idx;
    logic                 w_wfire, w_afire, w_wend;
    logic [CCW-1:0]       r_cols;
    logic signed [DW-1:0] r_w    [ROWS][COLS];
    logic signed [SW-1:0] r_psum [ROWS][COLS];
    logic signed [DW-1:0] w_a_in [ROWS];
    logic signed [DW-1:0] w_pe_a [ROWS][COLS];
    logic signed [PW-1:0] w_prod [ROWS][COLS];
    logic signed [SW-1:0] w_pin  [ROWS][COLS];
    logic signed [SW-1:0] w_dsk  [COLS];
    logic [L-2:0]         r_vld, r_lst;

`ifdef SYSTOLIC_WS_SAT_EN
    localparam int XW = ((AW > SW) ? AW : SW) + 1;
    localparam logic signed [XW-1:0] SAT_HI = {{(XW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_LO = {{(XW-AW+1){1'b1}}, {(AW-1){1'b0}}};
`endif

    function automatic logic signed [AW-1:0] conv_out(input logic signed [SW-1:0] s);
`ifdef SYSTOLIC_WS_SAT_EN
        logic signed [XW-1:0] x;
        x = XW'(s);
        if (x > SAT_HI)
            x = SAT_HI;
        else if (x < SAT_LO)
            x = SAT_LO;
        return AW'(x);
`else
        return AW'(s);
`endif
    endfunction

    assign state = r_state;

    // A weight beat in LOADED takes priority over a simultaneous activation beat.
    always_comb begin
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        w_idx       = '0;
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY:  w_ready = 1'b1;
            S_LOAD: begin
                w_ready = 1'b1;
                w_idx   = r_wcnt;
            end
            S_LOADED: begin
                w_ready = 1'b1;
                a_ready = ~w_valid;
            end
            S_STREAM: a_ready = 1'b1;
            default:  ;
        endcase
        w_wfire = w_valid & w_ready;
        w_afire = a_valid & a_ready;
        w_wend  = w_last | (w_idx == CW'(ROWS-1));
        case (r_state)
            S_EMPTY, S_LOAD: if (w_wfire) w_state_nxt = w_wend ? S_LOADED : S_LOAD;
            S_LOADED: begin
                if (w_wfire)
                    w_state_nxt = w_wend ? S_LOADED : S_LOAD;
                else if (w_afire)
                    w_state_nxt = a_last ? S_DRAIN : S_STREAM;
            end
            S_STREAM: if (w_afire && a_last) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (o_valid && o_last) w_state_nxt = S_LOADED;
            default:  w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_wcnt  <= '0;
            r_cols  <= COLS_C;
        end else begin
            r_state <= w_state_nxt;
            if (w_wfire)
                r_wcnt <= w_wend ? '0 : w_idx + CW'(1);
            if (cfg_valid && (r_state == S_EMPTY || r_state == S_LOADED))
                r_cols <= (cfg_cols > COLS_C) ? COLS_C : cfg_cols;
        end
    end

    // The first beat of a load clears every row so rows left unwritten end up zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_w[r][c] <= '0;
        end else if (w_wfire) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (CW'(r) == w_idx)
                        r_w[r][c] <= $signed(w_data[c*DW +: DW]);
                    else if (r_state != S_LOAD)
                        r_w[r][c] <= '0;
        end
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++)
            w_a_in[r] = w_afire ? $signed(a_data[r*DW +: DW]) : '0;
    end

    // Row r's activation passes r skew registers, then one register per PE column.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        localparam int N = r + COLS - 1;
        if (N > 0) begin : g_chain
            logic signed [DW-1:0] r_sh [N];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < N; i++)
                        r_sh[i] <= '0;
                end else begin
                    r_sh[0] <= w_a_in[r];
                    for (int i = 1; i < N; i++)
                        r_sh[i] <= r_sh[i-1];
                end
            end
            for (genvar c = 0; c < COLS; c++) begin : g_tap
                if (r + c == 0) begin : g_direct
                    assign w_pe_a[r][c] = w_a_in[r];
                end else begin : g_reg
                    assign w_pe_a[r][c] = r_sh[r+c-1];
                end
            end
        end else begin : g_nochain
            assign w_pe_a[r][0] = w_a_in[r];
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++)
            w_pin[0][c] = '0;
        for (int r = 1; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_pin[r][c] = r_psum[r-1][c];
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                w_prod[r][c] = PW'(w_pe_a[r][c]) * PW'(r_w[r][c]);
    end

    // PE stage: partial sums move down one row per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_psum[r][c] <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_psum[r][c] <= w_pin[r][c] + SW'(w_prod[r][c]);
        end
    end

    // Deskew stage: column c waits COLS-1-c cycles so all columns line up.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        if (D > 0) begin : g_dly
            logic signed [SW-1:0] r_dl [D];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++)
                        r_dl[i] <= '0;
                end else begin
                    r_dl[0] <= r_psum[ROWS-1][c];
                    for (int i = 1; i < D; i++)
                        r_dl[i] <= r_dl[i-1];
                end
            end
            assign w_dsk[c] = r_dl[D-1];
        end else begin : g_nodly
            assign w_dsk[c] = r_psum[ROWS-1][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_lst <= '0;
        end else begin
            r_vld[0] <= w_afire;
            r_lst[0] <= w_afire & a_last;
            for (int i = 1; i <= L-2; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_lst[i] <= r_lst[i-1];
            end
        end
    end

    // Output stage: conversion, column mask, hold data while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= r_vld[L-2];
            o_last  <= r_vld[L-2] & r_lst[L-2];
            if (r_vld[L-2])
                for (int c = 0; c < COLS; c++)
                    o_data[c*AW +: AW] <= (CCW'(c) < r_cols) ? conv_out(w_dsk[c]) : '0;
        end
    end

endmodule

// File: tb/tb_systolic_ws_array.sv
// Directed bench for systolic_ws_array in a 2x2, DW=16, AW=24 configuration.
module tb_systolic_ws_array;
    localparam int ROWS = 2;
    localparam int COLS = 2;
    localparam int DW   = 16;
    localparam int AW   = 24;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      cfg_valid;
    logic [$clog2(COLS+1)-1:0] cfg_cols;
    logic                      w_valid;
    logic                      w_ready;
    logic [COLS*DW-1:0]        w_data;
    logic                      w_last;
    logic                      a_valid;
    logic                      a_ready;
    logic [ROWS*DW-1:0]        a_data;
    logic                      a_last;
    logic                      o_valid;
    logic [COLS*AW-1:0]        o_data;
    logic                      o_last;
    logic [2:0]                state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    systolic_ws_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_cols(cfg_cols),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
        .state(state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wbeat(input int c0, input int c1, input logic last);
        w_valid = 1'b1;
        w_data  = {16'(c1), 16'(c0)};
        w_last  = last;
        tick();
        w_valid = 1'b0;
        w_last  = 1'b0;
    endtask

    task automatic abeat(input int e0, input int e1, input logic last);
        a_valid = 1'b1;
        a_data  = {16'(e1), 16'(e0)};
        a_last  = last;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic set_cols(input int n);
        cfg_valid = 1'b1;
        cfg_cols  = 2'(n);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Called in the cycle after acceptance; returns the cycle offset of the next o_valid.
    task automatic wait_out(output int n);
        n = 1;
        while (!o_valid && n < 16) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_valid = 1'b0; cfg_cols = '0;
        w_valid = 1'b0; w_data = '0; w_last = 1'b0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0;
        tick();
        tick();
        n_vec++; if (state !== 3'd0)  begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
        n_vec++; if (w_ready !== 1'b1) begin n_err++; $display("FAIL reset_w_ready: got %b want 1", w_ready); end
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
        n_vec++; if (o_valid !== 1'b0 || o_last !== 1'b0) begin n_err++; $display("FAIL reset_o_flags: got %b%b want 00", o_valid, o_last); end
        n_vec++; if (o_data !== '0) begin n_err++; $display("FAIL reset_o_data: got %h want 0", o_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        wbeat(1, 2, 1'b0);
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL basic_load_state: got %0d want 1", state); end
        wbeat(3, 4, 1'b1);
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL basic_loaded_state: got %0d want 2", state); end
        abeat(5, 6, 1'b1);
        n_vec++; if (state !== 3'd4) begin n_err++; $display("FAIL basic_drain_state: got %0d want 4", state); end
        wait_out(n);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", n); end
        n_vec++; if (o_data !== {24'(34), 24'(23)}) begin n_err++; $display("FAIL basic_data: got %h want %h", o_data, {24'(34), 24'(23)}); end
        n_vec++; if (o_last !== 1'b1) begin n_err++; $display("FAIL basic_last: got %b want 1", o_last); end
        tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL basic_return_state: got %0d want 2", state); end
        n_vec++; if (o_valid !== 1'b0 || o_data !== {24'(34), 24'(23)}) begin n_err++; $display("FAIL basic_hold: got v=%b d=%h want v=0 d=%h", o_valid, o_data, {24'(34), 24'(23)}); end
    endtask

    task automatic test_bubbles();
        abeat(-1, 2, 1'b0);
        n_vec++; if (state !== 3'd3) begin n_err++; $display("FAIL bub_stream_state: got %0d want 3", state); end
        tick();
        abeat(7, 0, 1'b1);
        tick();
        n_vec++; if (o_valid !== 1'b1 || o_last !== 1'b0) begin n_err++; $display("FAIL bub_first_flags: got v=%b l=%b want v=1 l=0", o_valid, o_last); end
        n_vec++; if (o_data !== {24'(6), 24'(5)}) begin n_err++; $display("FAIL bub_first_data: got %h want %h", o_data, {24'(6), 24'(5)}); end
        tick();
        n_vec++; if (o_valid !== 1'b0 || o_data !== {24'(6), 24'(5)}) begin n_err++; $display("FAIL bub_gap: got v=%b d=%h want v=0 d=%h", o_valid, o_data, {24'(6), 24'(5)}); end
        tick();
        n_vec++; if (o_valid !== 1'b1 || o_last !== 1'b1) begin n_err++; $display("FAIL bub_second_flags: got v=%b l=%b want v=1 l=1", o_valid, o_last); end
        n_vec++; if (o_data !== {24'(14), 24'(7)}) begin n_err++; $display("FAIL bub_second_data: got %h want %h", o_data, {24'(14), 24'(7)}); end
        tick();
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL bub_return_state: got %0d want 2", state); end
    endtask

    task automatic test_short_load_mask();
        int n;
        wbeat(1, 2, 1'b1);
        n_vec++; if (state !== 3'd2) begin n_err++; $display("FAIL short_load_state: got %0d want 2", state); end
        set_cols(1);
        abeat(5, 6, 1'b1);
        wait_out(n);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL mask1_latency: got %0d want 4", n); end
        n_vec++; if (o_data !== {24'(0), 24'(5)}) begin n_err++; $display("FAIL mask1_data: got %h want %h", o_data, {24'(0), 24'(5)}); end
        tick();
        set_cols(3);
        abeat(5, 6, 1'b1);
        wait_out(n);
        n_vec++; if (o_data !== {24'(10), 24'(5)}) begin n_err++; $display("FAIL clamp_data: got %h want %h", o_data, {24'(10), 24'(5)}); end
        tick();
        set_cols(0);
        abeat(5, 6, 1'b1);
        wait_out(n);
        n_vec++; if (o_valid !== 1'b1 || o_data !== '0) begin n_err++; $display("FAIL mask0: got v=%b d=%h want v=1 d=0", o_valid, o_data); end
        tick();
        set_cols(2);
    endtask

    task automatic test_handshake();
        int n;
        w_valid = 1'b1; w_data = {16'(2), 16'(1)}; w_last = 1'b0;
        a_valid = 1'b1; a_data = {16'(6), 16'(5)}; a_last = 1'b1;
        #1;
        n_vec++; if (w_ready !== 1'b1 || a_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready: got w=%b a=%b want w=1 a=0", w_ready, a_ready); end
        tick();
        w_valid = 1'b0; a_valid = 1'b0; a_last = 1'b0;
        n_vec++; if (state !== 3'd1) begin n_err++; $display("FAIL prio_state: got %0d want 1", state); end
        wbeat(3, 4, 1'b1);
        abeat(1, 1, 1'b0);
        n_vec++; if (state !== 3'd3 || w_ready !== 1'b0) begin n_err++; $display("FAIL stream_wready: got s=%0d w=%b want s=3 w=0", state, w_ready); end
        set_cols(1);
        abeat(2, 3, 1'b1);
        wait_out(n);
        n_vec++; if (n !== 2) begin n_err++; $display("FAIL hs_first_offset: got %0d want 2", n); end
        n_vec++; if (o_data !== {24'(6), 24'(4)}) begin n_err++; $display("FAIL hs_first_data: got %h want %h", o_data, {24'(6), 24'(4)}); end
        tick();
        tick();
        n_vec++; if (o_valid !== 1'b1 || o_last !== 1'b1 || o_data !== {24'(16), 24'(11)}) begin n_err++; $display("FAIL cfg_ignored: got v=%b l=%b d=%h want v=1 l=1 d=%h", o_valid, o_last, o_data, {24'(16), 24'(11)}); end
        tick();
    endtask

    task automatic test_saturation();
        int n;
        int exp0;
`ifdef SYSTOLIC_WS_SAT_EN
        exp0 = 8388607;
`else
        exp0 = -131070;
`endif
        wbeat(32767, 0, 1'b0);
        wbeat(32767, 0, 1'b1);
        abeat(32767, 32767, 1'b1);
        wait_out(n);
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL sat_latency: got %0d want 4", n); end
        n_vec++; if (o_data !== {24'(0), 24'(exp0)}) begin n_err++; $display("FAIL sat_data: got %h want %h", o_data, {24'(0), 24'(exp0)}); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        abeat(5, 6, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        n_vec++; if (state !== 3'd0 || o_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_state: got s=%0d v=%b want s=0 v=0", state, o_valid); end
        n_vec++; if (w_ready !== 1'b1 || o_data !== '0) begin n_err++; $display("FAIL mid_reset_out: got w=%b d=%h want w=1 d=0", w_ready, o_data); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (o_valid) seen++;
        end
        n_vec++; if (seen !== 0) begin n_err++; $display("FAIL late_output: got %0d valid cycles want 0", seen); end
        a_valid = 1'b1; a_data = {16'(6), 16'(5)}; a_last = 1'b1;
        #1;
        n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL refuse_a_ready: got %b want 0", a_ready); end
        tick();
        a_valid = 1'b0; a_last = 1'b0;
        n_vec++; if (state !== 3'd0) begin n_err++; $display("FAIL refuse_state: got %0d want 0", state); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bubbles();
        test_short_load_mask();
        test_handshake();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
